// File: rtl/ppc_types.sv
// Shared PowerPC execution-unit types.
// Divide decode, condition/exception flags, divider lane state.
package ppc_types;

  typedef struct packed {
    logic div_signed;
    logic alter_cr0;
    logic alter_ov;
  } div_decode_t;

  typedef struct packed {
    logic cr0_lt;
    logic cr0_gt;
    logic cr0_eq;
    logic cr0_so;
    logic xer_ov;
    logic xer_so;
    logic alter_cr0;
    logic alter_ov;
  } cond_exception_t;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_SETUP,
    DIV_ITER,
    DIV_DONE
  } div_lane_state_t;

endpackage

// File: rtl/div_unit_mp_lane.sv
// One iterative restoring divider lane.
// Holds its op from issue until the retire handshake.
module div_lane
  import ppc_types::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int RS_ID_WIDTH    = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue,
  input  logic                   retire,
  input  logic [WIDTH-1:0]       op1,
  input  logic [WIDTH-1:0]       op2,
  input  div_decode_t            ctrl,
  input  logic [RS_ID_WIDTH-1:0] rs_id_in,
  input  logic [4:0]             addr_in,
  output logic                   idle,
  output logic                   done,
  output logic [RS_ID_WIDTH-1:0] rs_id_out,
  output logic [4:0]             addr_out,
  output logic [WIDTH-1:0]       result,
  output cond_exception_t        flags
);

  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CW    = $clog2(STEPS) + 1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_lane_state_t        state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]       rem_q, rem_d;
  logic [WIDTH-1:0]       quo_q, quo_d;
  logic [WIDTH-1:0]       dvs_q, dvs_d;
  logic                   neg_q, neg_d;
  logic                   ov_q, ov_d;
  div_decode_t            ctrl_q, ctrl_d;
  logic [RS_ID_WIDTH-1:0] rs_q, rs_d;
  logic [4:0]             addr_q, addr_d;

  logic [WIDTH:0]         step_rem;
  logic [WIDTH-1:0]       step_quo;
  logic                   a_neg, b_neg, exc;

  // Unrolled restoring steps; quo_q shifts dividend bits out, quotient bits in
  always_comb begin
    step_rem = {1'b0, rem_q};
    step_quo = quo_q;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      step_rem = {step_rem[WIDTH-1:0], step_quo[WIDTH-1]};
      step_quo = {step_quo[WIDTH-2:0], 1'b0};
      if (step_rem >= {1'b0, dvs_q}) begin
        step_rem    = step_rem - {1'b0, dvs_q};
        step_quo[0] = 1'b1;
      end
    end
  end

  // Lane FSM and datapath next-state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    neg_d   = neg_q;
    ov_d    = ov_q;
    ctrl_d  = ctrl_q;
    rs_d    = rs_q;
    addr_d  = addr_q;
    a_neg   = ctrl_q.div_signed & quo_q[WIDTH-1];
    b_neg   = ctrl_q.div_signed & dvs_q[WIDTH-1];
    exc     = (dvs_q == '0) |
              (ctrl_q.div_signed & (quo_q == MOST_NEG) &
               (dvs_q == '1));
    case (state_q)
      DIV_IDLE: begin
        if (issue) begin
          state_d = DIV_SETUP;
          quo_d   = op1;
          dvs_d   = op2;
          rem_d   = '0;
          neg_d   = 1'b0;
          ov_d    = 1'b0;
          ctrl_d  = ctrl;
          rs_d    = rs_id_in;
          addr_d  = addr_in;
        end
      end
      DIV_SETUP: begin
        if (exc) begin
          quo_d   = '0;
          ov_d    = ctrl_q.alter_ov;
          state_d = DIV_DONE;
        end else begin
          quo_d   = a_neg ? -quo_q : quo_q;
          dvs_d   = b_neg ? -dvs_q : dvs_q;
          neg_d   = a_neg ^ b_neg;
          cnt_d   = CW'(STEPS - 1);
          state_d = DIV_ITER;
        end
      end
      DIV_ITER: begin
        rem_d = step_rem[WIDTH-1:0];
        quo_d = step_quo;
        if (cnt_q == '0) begin
          quo_d   = neg_q ? -step_quo : step_quo;
          state_d = DIV_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DIV_DONE: begin
        if (retire) state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  // Lane state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      neg_q   <= 1'b0;
      ov_q    <= 1'b0;
      ctrl_q  <= '0;
      rs_q    <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      neg_q   <= neg_d;
      ov_q    <= ov_d;
      ctrl_q  <= ctrl_d;
      rs_q    <= rs_d;
      addr_q  <= addr_d;
    end
  end

  // Status, payload and CR0/XER flags of the finished quotient
  always_comb begin
    idle            = (state_q == DIV_IDLE);
    done            = (state_q == DIV_DONE);
    rs_id_out       = rs_q;
    addr_out        = addr_q;
    result          = quo_q;
    flags.cr0_lt    = quo_q[WIDTH-1];
    flags.cr0_eq    = (quo_q == '0);
    flags.cr0_gt    = ~quo_q[WIDTH-1] & (quo_q != '0);
    flags.cr0_so    = ov_q;
    flags.xer_ov    = ov_q;
    flags.xer_so    = ov_q;
    flags.alter_cr0 = ctrl_q.alter_cr0;
    flags.alter_ov  = ctrl_q.alter_ov;
  end

endmodule

// File: rtl/div_unit_mp.sv
// Multi-lane integer divide unit.
// Round-robin issue into lanes, strictly in-order retire.
module div_unit_mp
  import ppc_types::*;
#(
  parameter int RS_ID_WIDTH    = 5,
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int NUM_LANES      = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   input_valid,
  output logic                   input_ready,
  input  logic [RS_ID_WIDTH-1:0] rs_id_in,
  input  logic [4:0]             result_reg_addr_in,
  input  logic [WIDTH-1:0]       op1,
  input  logic [WIDTH-1:0]       op2,
  input  div_decode_t            control,
  output logic                   output_valid,
  input  logic                   output_ready,
  output logic [RS_ID_WIDTH-1:0] rs_id_out,
  output logic [4:0]             result_reg_addr_out,
  output logic [WIDTH-1:0]       result,
  output cond_exception_t        cr0_xer
);

  localparam int PW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic [PW-1:0]          issue_ptr_q, issue_ptr_d;
  logic [PW-1:0]          retire_ptr_q, retire_ptr_d;
  logic [NUM_LANES-1:0]   lane_issue, lane_retire;
  logic                   lane_idle [NUM_LANES];
  logic                   lane_done [NUM_LANES];
  logic [RS_ID_WIDTH-1:0] lane_rs   [NUM_LANES];
  logic [4:0]             lane_addr [NUM_LANES];
  logic [WIDTH-1:0]       lane_res  [NUM_LANES];
  cond_exception_t        lane_flg  [NUM_LANES];
  logic                   issue_fire, retire_fire;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    div_lane #(
      .WIDTH         (WIDTH),
      .BITS_PER_CYCLE(BITS_PER_CYCLE),
      .RS_ID_WIDTH   (RS_ID_WIDTH)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .issue    (lane_issue[l]),
      .retire   (lane_retire[l]),
      .op1      (op1),
      .op2      (op2),
      .ctrl     (control),
      .rs_id_in (rs_id_in),
      .addr_in  (result_reg_addr_in),
      .idle     (lane_idle[l]),
      .done     (lane_done[l]),
      .rs_id_out(lane_rs[l]),
      .addr_out (lane_addr[l]),
      .result   (lane_res[l]),
      .flags    (lane_flg[l])
    );
  end

  // Handshakes, per-lane strobes, pointer advance and output mux
  always_comb begin
    input_ready  = ~rst & lane_idle[issue_ptr_q];
    output_valid = ~rst & lane_done[retire_ptr_q];
    issue_fire   = input_valid & input_ready;
    retire_fire  = output_valid & output_ready;
    for (int l = 0; l < NUM_LANES; l++) begin
      lane_issue[l]  = issue_fire & (issue_ptr_q == PW'(l));
      lane_retire[l] = retire_fire & (retire_ptr_q == PW'(l));
    end
    issue_ptr_d  = issue_ptr_q;
    retire_ptr_d = retire_ptr_q;
    if (issue_fire)
      issue_ptr_d = (issue_ptr_q == PW'(NUM_LANES - 1)) ?
                    '0 : issue_ptr_q + 1'b1;
    if (retire_fire)
      retire_ptr_d = (retire_ptr_q == PW'(NUM_LANES - 1)) ?
                     '0 : retire_ptr_q + 1'b1;
    rs_id_out           = '0;
    result_reg_addr_out = '0;
    result              = '0;
    cr0_xer             = '0;
    if (output_valid) begin
      rs_id_out           = lane_rs[retire_ptr_q];
      result_reg_addr_out = lane_addr[retire_ptr_q];
      result              = lane_res[retire_ptr_q];
      cr0_xer             = lane_flg[retire_ptr_q];
    end
  end

  // Issue and retire pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_ptr_q  <= '0;
      retire_ptr_q <= '0;
    end else begin
      issue_ptr_q  <= issue_ptr_d;
      retire_ptr_q <= retire_ptr_d;
    end
  end

endmodule

// File: tb/tb_div_unit_mp.sv
// Directed bench for div_unit_mp in two configurations:
// (1 bit/cycle, 2 lanes) and (4 bits/cycle, 4 lanes).
module tb_div_unit_mp;
  import ppc_types::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic [1:0]            i_valid, i_ready, o_valid, o_ready;
  logic [1:0][4:0]       i_rs, i_addr, o_rs, o_addr;
  logic [1:0][31:0]      i_op1, i_op2, o_res;
  div_decode_t     [1:0] i_ctrl;
  cond_exception_t [1:0] o_flg;

  int n_cmp = 0;
  int n_bad = 0;

  div_unit_mp #(
    .RS_ID_WIDTH(5), .WIDTH(32), .BITS_PER_CYCLE(1), .NUM_LANES(2)
  ) u0 (
    .clk(clk), .rst(rst),
    .input_valid(i_valid[0]), .input_ready(i_ready[0]),
    .rs_id_in(i_rs[0]), .result_reg_addr_in(i_addr[0]),
    .op1(i_op1[0]), .op2(i_op2[0]), .control(i_ctrl[0]),
    .output_valid(o_valid[0]), .output_ready(o_ready[0]),
    .rs_id_out(o_rs[0]), .result_reg_addr_out(o_addr[0]),
    .result(o_res[0]), .cr0_xer(o_flg[0])
  );

  div_unit_mp #(
    .RS_ID_WIDTH(5), .WIDTH(32), .BITS_PER_CYCLE(4), .NUM_LANES(4)
  ) u1 (
    .clk(clk), .rst(rst),
    .input_valid(i_valid[1]), .input_ready(i_ready[1]),
    .rs_id_in(i_rs[1]), .result_reg_addr_in(i_addr[1]),
    .op1(i_op1[1]), .op2(i_op2[1]), .control(i_ctrl[1]),
    .output_valid(o_valid[1]), .output_ready(o_ready[1]),
    .rs_id_out(o_rs[1]), .result_reg_addr_out(o_addr[1]),
    .result(o_res[1]), .cr0_xer(o_flg[1])
  );

  typedef struct {
    bit          sg, acr, aov;
    logic [31:0] a, b, q;
    bit          lt, gt, eq, ov, early;
  } vec_t;

  vec_t vt [11];

  function automatic int lat(int c, bit early);
    return early ? 2 : (c == 0 ? 32 : 8) + 2;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(int c, bit sg, bit acr, bit aov,
                       logic [31:0] a, logic [31:0] b,
                       logic [4:0] rs, logic [4:0] ad);
    i_ctrl[c] = '{div_signed: sg, alter_cr0: acr, alter_ov: aov};
    i_op1[c]  = a;
    i_op2[c]  = b;
    i_rs[c]   = rs;
    i_addr[c] = ad;
  endtask

  task automatic issue(int c, bit sg, bit acr, bit aov,
                       logic [31:0] a, logic [31:0] b,
                       logic [4:0] rs, logic [4:0] ad);
    int k;
    @(negedge clk);
    drive(c, sg, acr, aov, a, b, rs, ad);
    i_valid[c] = 1'b1;
    k = 0;
    while (!i_ready[c] && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("issue_ready", 32'(i_ready[c]), 32'd1);
    @(posedge clk);
    #1 i_valid[c] = 1'b0;
  endtask

  task automatic wait_valid(int c, output int n);
    n = 1;
    while (!o_valid[c] && n < 400) begin
      @(posedge clk);
      #1 n++;
    end
  endtask

  task automatic run_vec(int c, vec_t v, logic [4:0] rs);
    int n;
    logic [7:0] ef;
    ef = {v.lt, v.gt, v.eq, v.ov, v.ov, v.ov, v.acr, v.aov};
    o_ready[c] = 1'b1;
    issue(c, v.sg, v.acr, v.aov, v.a, v.b, rs, 5'd7);
    wait_valid(c, n);
    chk("latency", 32'(n), 32'(lat(c, v.early)));
    chk("result", o_res[c], v.q);
    chk("flags", 32'(o_flg[c]), 32'(ef));
    chk("rs_id", 32'(o_rs[c]), 32'(rs));
    chk("addr", 32'(o_addr[c]), 32'd7);
    @(posedge clk);
    #1 chk("retired", 32'(o_valid[c]), 32'd0);
  endtask

  task automatic ordering(int c);
    int nl, got, cyc;
    bit pend;
    nl = (c == 0) ? 2 : 4;
    o_ready[c] = 1'b0;
    for (int i = 0; i <= nl; i++) begin
      @(negedge clk);
      if (i == 1)
        drive(c, 0, 0, 1, 32'd3948934, 32'd0, 5'(5 - i), 5'(i));
      else
        drive(c, 0, 0, 0, 32'd100, 32'd7, 5'(5 - i), 5'(i));
      i_valid[c] = 1'b1;
      chk(i < nl ? "ord_ready" : "ord_full",
          32'(i_ready[c]), i < nl ? 32'd1 : 32'd0);
    end
    repeat (40) @(negedge clk);
    chk("ord_held", 32'(i_ready[c]), 32'd0);
    o_ready[c] = 1'b1;
    got = 0;
    cyc = 0;
    while (got <= nl && cyc < 200) begin
      pend = i_valid[c] & i_ready[c];
      if (o_valid[c]) begin
        chk("ord_rs", 32'(o_rs[c]), 32'(5 - got));
        chk("ord_res", o_res[c], got == 1 ? 32'd0 : 32'd14);
        got++;
      end
      @(posedge clk);
      if (pend) #1 i_valid[c] = 1'b0;
      @(negedge clk);
      cyc++;
    end
    i_valid[c] = 1'b0;
    chk("ord_count", 32'(got), 32'(nl + 1));
  endtask

  task automatic stall(int c);
    o_ready[c] = 1'b0;
    issue(c, 0, 0, 0, 32'd25, 32'd5, 5'd9, 5'd3);
    issue(c, 1, 0, 0, 32'd179, 32'd16, 5'd10, 5'd4);
    repeat (40) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(o_valid[c]), 32'd1);
      chk("stall_res", o_res[c], 32'd5);
      chk("stall_rs", 32'(o_rs[c]), 32'd9);
      chk("stall_addr", 32'(o_addr[c]), 32'd3);
    end
    o_ready[c] = 1'b1;
    @(posedge clk);
    #1;
    chk("next_valid", 32'(o_valid[c]), 32'd1);
    chk("next_rs", 32'(o_rs[c]), 32'd10);
    chk("next_res", o_res[c], 32'd11);
    @(posedge clk);
    #1 chk("stall_drain", 32'(o_valid[c]), 32'd0);
  endtask

  task automatic mid_reset(int c);
    int seen;
    o_ready[c] = 1'b1;
    issue(c, 0, 0, 0, 32'hFFFF_FFFF, 32'd3, 5'd1, 5'd1);
    issue(c, 0, 0, 0, 32'hFFFF_FFFF, 32'd5, 5'd2, 5'd2);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_valid", 32'(o_valid[c]), 32'd0);
    chk("rst_ready", 32'(i_ready[c]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 chk("post_rst_ready", 32'(i_ready[c]), 32'd1);
    seen = 0;
    repeat (45) begin
      @(negedge clk);
      if (o_valid[c]) seen++;
    end
    chk("dropped", 32'(seen), 32'd0);
    run_vec(c, vt[5], 5'd17);
  endtask

  initial begin
    vt[0]  = '{0,0,0, 32'd25, 32'd5, 32'd5, 0,1,0,0,0};
    vt[1]  = '{1,1,0, -32'sd25, 32'd5, 32'hFFFF_FFFB, 1,0,0,0,0};
    vt[2]  = '{1,0,0, 32'd179, 32'd16, 32'd11, 0,1,0,0,0};
    vt[3]  = '{1,0,1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0,0,1,1,1};
    vt[4]  = '{0,0,1, 32'd3948934, 32'd0, 32'd0, 0,0,1,1,1};
    vt[5]  = '{0,0,0, 32'hFFFF_FFFF, 32'd3857369, 32'd1113, 0,1,0,0,0};
    vt[6]  = '{1,1,1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1,0,0,0,0};
    vt[7]  = '{1,0,0, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 0,1,0,0,0};
    vt[8]  = '{0,0,0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0,0,1,0,0};
    vt[9]  = '{1,1,0, 32'd0, 32'd5, 32'd0, 0,0,1,0,0};
    vt[10] = '{0,0,0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1,0,0,0,0};

    rst     = 1'b1;
    i_valid = '0;
    o_ready = '0;
    i_rs    = '0;
    i_addr  = '0;
    i_op1   = '0;
    i_op2   = '0;
    i_ctrl  = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      chk("reset_valid", 32'(o_valid[c]), 32'd0);
      chk("reset_ready", 32'(i_ready[c]), 32'd0);
      chk("reset_res", o_res[c], 32'd0);
      chk("reset_rs", 32'(o_rs[c]), 32'd0);
      chk("reset_flags", 32'(o_flg[c]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 11; i++) run_vec(c, vt[i], 5'(i + 1));
      ordering(c);
      stall(c);
      mid_reset(c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div_unit_mp.md
Name: div_unit_mp

Overview:
- Parametrised successor of the integer divide execution unit (divw/divwu and their ./o forms).
- Holds NUM_LANES independent iterative dividers behind one ready/valid issue port; each divider retires BITS_PER_CYCLE quotient bits per cycle.
- Results retire strictly in issue order to the result bus / CDB arbiter.
- Sits between the divide reservation station and the completion arbiter.

Parameters:
- RS_ID_WIDTH, 5, width of reservation-station tag carried through.
- WIDTH, 32, operand/result width; even, >= 8.
- BITS_PER_CYCLE, 1, quotient bits per iteration; power of two dividing WIDTH.
- NUM_LANES, 2, parallel divider lanes; power of two, 1..8.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- input_valid  in  1  issue request.
- input_ready  out  1  issue accepted when both valid and ready are high at posedge.
- rs_id_in  in  RS_ID_WIDTH  tag.
- result_reg_addr_in  in  5  destination GPR.
- op1  in  WIDTH  dividend (RA).
- op2  in  WIDTH  divisor (RB).
- control  in  div_decode_t  {div_signed, alter_CR0, alter_OV}.
- output_valid  out  1  result available.
- output_ready  in  1  consumer accepts.
- rs_id_out  out  RS_ID_WIDTH  tag of the retiring op.
- result_reg_addr_out  out  5  GPR of the retiring op.
- result  out  WIDTH  quotient.
- cr0_xer  out  cond_exception_t  CR0 LT/GT/EQ/SO and XER OV/SO, with alter flags.

Behaviour:
- Reset: all lanes IDLE; issue_ptr=0, retire_ptr=0; output_valid=0, input_ready=0 during the reset cycle; result/rs_id_out/result_reg_addr_out/cr0_xer=0.
- Lane FSM: IDLE -> (issue) SETUP -> ITER x (WIDTH/BITS_PER_CYCLE) -> DONE -> (retire handshake) IDLE.
- Early-out: divisor==0, or signed op1=most-negative with op2=-1 -> SETUP -> DONE directly.
- Issue:
  - input_ready = lane[issue_ptr] is IDLE (combinational from lane state only, never from input_valid).
  - On handshake, latch operands/tag/control into lane[issue_ptr]; issue_ptr increments modulo NUM_LANES.
- Retire:
  - output_valid = lane[retire_ptr] is DONE; outputs driven from that lane.
  - On output_valid & output_ready, the lane returns to IDLE and retire_ptr increments.
  - Outputs hold stable while valid and not ready.
- Latency: issue edge to output_valid = WIDTH/BITS_PER_CYCLE + 2 cycles (34 for defaults); early-out = 2 cycles.
- Throughput: NUM_LANES ops in flight. Back-to-back issue is allowed when the next lane is idle.
- A lane freed by retire in cycle N can accept an issue in cycle N+1 (no same-cycle bypass).
- In-order retire: an early-out lane waits in DONE behind an older unfinished lane.
- Arithmetic:
  - Unsigned: restoring division, BITS_PER_CYCLE steps unrolled per iteration.
  - Signed: divide magnitudes; negate the quotient iff operand signs differ; truncate toward zero. Remainder is discarded.
- Exceptional cases:
  - Divide-by-zero or signed overflow: result=0; OV=1 (XER SO=1) when alter_OV.
  - CR0 is computed from result=0, i.e. EQ=1.
  - Otherwise OV=0.
- CR0: LT/GT/EQ from the signed interpretation of result; CR0.SO = computed OV. The alter_CR0 and alter_OV flags pass through; downstream merges the architectural SO.
- Reset mid-operation: all in-flight ops are dropped with no output. output_valid is 0 the cycle after rst.
- Simultaneous issue and retire on the same lane index is only possible if that lane is IDLE for issue. An issue and a retire in the same cycle on different lanes are independent.

Decomposition:
- ppc_types (existing): div_decode_t, cond_exception_t.
- Add to ppc_types: div_lane_state_t enum {DIV_IDLE, DIV_SETUP, DIV_ITER, DIV_DONE}.
- Sub-module div_lane (WIDTH, BITS_PER_CYCLE, RS_ID_WIDTH) contains:
  - the FSM, iteration counter, and partial-remainder/quotient registers;
  - sign fix-up and flag generation.
- Top level holds the issue/retire pointers and the output mux.

Test Plan:
- Unsigned 25/5, alter off -> result=5, OV=0, output_valid exactly 34 cycles after issue (defaults).
- Signed -25/5 with alter_CR0=1 -> result=0xFFFFFFFB, CR0 LT=1; signed 179/16 -> 11, GT=1.
- Signed 0x80000000/-1 with alter_OV=1, and unsigned 3948934/0 with alter_OV=1 -> result=0, OV=1, SO=1, EQ=1, 2-cycle latency.
- Ordering with NUM_LANES=2 and output_ready=0:
  - Issue 3 ops back-to-back; input_ready drops after 2 issues.
  - After enabling ready, outputs appear in issue order: rs_id 5, 4, then 3.
  - The early-out op issued second still retires second.
- Stall: output_ready held low 10 cycles while output_valid -> all outputs stable; retire on the first ready cycle; next op follows the cycle after.
- Assert rst while 2 lanes are in ITER -> output_valid=0 the next cycle, input_ready=1 the cycle after rst deasserts.
- A following 0xFFFFFFFF/3857369 unsigned -> 1113.
- Repeat all scenarios with BITS_PER_CYCLE=4, NUM_LANES=4.
